// File: rtl/wb_ram_arbiter.sv
// -----------------------------------------------------------------------------
// wb_ram_arbiter
//
// Two-master round-robin Wishbone arbiter placed directly in front of a single
// Wishbone RAM slave port. Whole bus cycles (framed by CYC) are granted; the
// winner's request lines are muxed to the slave and ACK is routed back to the
// winner only. Read data is broadcast to both masters from the slave.
//
// Parameters
//   DATA_WIDTH    data bus width (8, 16, 32, 64)
//   ADDR_WIDTH    address width
//   SELECT_WIDTH  byte-select width (DATA_WIDTH/8)
//   TIMEOUT       watchdog limit in cycles (2..65535), used only when the
//                 watchdog is compiled in
//
// Build option
//   WB_RAM_ARBITER_TIMEOUT_EN  when defined, a watchdog terminates a strobe
//                              that has not been acknowledged for TIMEOUT
//                              cycles with a one-cycle ERR pulse to the
//                              granted master. When undefined, mN_err_o is 0
//                              and stalled accesses wait indefinitely.
//
// Ports
//   clk, rst                  clock (rising edge), async active-high reset
//   m0_* / m1_*               Wishbone slave-side ports facing each master:
//                             adr_i, dat_i, we_i, sel_i, stb_i, cyc_i in;
//                             dat_o, ack_o, err_o out
//   s_adr_o .. s_cyc_o        muxed Wishbone request toward the RAM
//   s_dat_i, s_ack_i          RAM read data and acknowledge
// -----------------------------------------------------------------------------
module wb_ram_arbiter #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 16,
   parameter int SELECT_WIDTH = DATA_WIDTH / 8,
   parameter int TIMEOUT      = 16
) (
   input  logic                    clk,
   input  logic                    rst,

   input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
   input  logic [DATA_WIDTH-1:0]   m0_dat_i,
   output logic [DATA_WIDTH-1:0]   m0_dat_o,
   input  logic                    m0_we_i,
   input  logic [SELECT_WIDTH-1:0] m0_sel_i,
   input  logic                    m0_stb_i,
   input  logic                    m0_cyc_i,
   output logic                    m0_ack_o,
   output logic                    m0_err_o,

   input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
   input  logic [DATA_WIDTH-1:0]   m1_dat_i,
   output logic [DATA_WIDTH-1:0]   m1_dat_o,
   input  logic                    m1_we_i,
   input  logic [SELECT_WIDTH-1:0] m1_sel_i,
   input  logic                    m1_stb_i,
   input  logic                    m1_cyc_i,
   output logic                    m1_ack_o,
   output logic                    m1_err_o,

   output logic [ADDR_WIDTH-1:0]   s_adr_o,
   output logic [DATA_WIDTH-1:0]   s_dat_o,
   output logic                    s_we_o,
   output logic [SELECT_WIDTH-1:0] s_sel_o,
   output logic                    s_stb_o,
   output logic                    s_cyc_o,
   input  logic [DATA_WIDTH-1:0]   s_dat_i,
   input  logic                    s_ack_i
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t state_q;
   state_t state_d;

   // Index of the master that most recently released a grant; on a tie the
   // other master wins. Resets to 1 so master 0 wins the first tie.
   logic   last_q;
   logic   last_d;

   logic   gnt0;
   logic   gnt1;
   logic   cyc_raw;
   logic   stb_raw;
   logic   wd_fire;

   // ---- grant state register ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   // A grant is held for the whole CYC frame; the pointer moves only when a
   // grant is released, and a waiting master is handed the bus directly so
   // there is no idle cycle between owners.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      unique case (state_q)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i) begin
               state_d = last_q ? GNT0 : GNT1;
            end else if (m0_cyc_i) begin
               state_d = GNT0;
            end else if (m1_cyc_i) begin
               state_d = GNT1;
            end
         end
         GNT0: begin
            if (!m0_cyc_i) begin
               last_d  = 1'b0;
               state_d = m1_cyc_i ? GNT1 : IDLE;
            end
         end
         GNT1: begin
            if (!m1_cyc_i) begin
               last_d  = 1'b1;
               state_d = m0_cyc_i ? GNT0 : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---- combinational request mux / response routing ----
   assign gnt0 = (state_q == GNT0);
   assign gnt1 = (state_q == GNT1);

   // CYC and STB are qualified by the master's own CYC so a master that has
   // just dropped its cycle disappears from the slave in the same cycle, even
   // though the grant itself is only released at the next edge.
   assign cyc_raw = (gnt0 & m0_cyc_i) | (gnt1 & m1_cyc_i);
   assign stb_raw = (gnt0 & m0_cyc_i & m0_stb_i) | (gnt1 & m1_cyc_i & m1_stb_i);

   assign s_adr_o = gnt1 ? m1_adr_i : m0_adr_i;
   assign s_dat_o = gnt1 ? m1_dat_i : m0_dat_i;
   assign s_we_o  = gnt1 ? m1_we_i  : m0_we_i;
   assign s_sel_o = gnt1 ? m1_sel_i : m0_sel_i;
   assign s_cyc_o = cyc_raw;
   assign s_stb_o = stb_raw & ~wd_fire;

   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;

   // An ACK that arrives after the owner has dropped CYC is a leftover of an
   // abandoned cycle and is swallowed rather than handed to anyone.
   assign m0_ack_o = s_ack_i & gnt0 & m0_cyc_i;
   assign m1_ack_o = s_ack_i & gnt1 & m1_cyc_i;

`ifdef WB_RAM_ARBITER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] wd_cnt_q;

   // Fires on the TIMEOUT-th consecutive unacknowledged strobe cycle. The
   // strobe is withheld from the slave in that cycle so the RAM cannot
   // acknowledge the access that is being terminated with ERR.
   assign wd_fire = stb_raw & ~s_ack_i & (wd_cnt_q == CNT_W'(TIMEOUT - 1));

   // ---- watchdog counter ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt_q <= '0;
      end else if (!stb_raw || s_ack_i || wd_fire) begin
         wd_cnt_q <= '0;
      end else begin
         wd_cnt_q <= wd_cnt_q + 1'b1;
      end
   end

   assign m0_err_o = wd_fire & gnt0;
   assign m1_err_o = wd_fire & gnt1;
`else
   // TIMEOUT only has meaning when the watchdog is built in.
   localparam int unused_timeout = TIMEOUT;

   assign wd_fire  = 1'b0;
   assign m0_err_o = 1'b0;
   assign m1_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_ram_arbiter
//
// Directed bench for wb_ram_arbiter with a behavioural single-cycle-ack RAM.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_wb_ram_arbiter;

   localparam int DW = 32;
   localparam int AW = 16;
   localparam int SW = DW / 8;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;

   logic [AW-1:0] m0_adr = '0;
   logic [DW-1:0] m0_dat = '0;
   logic          m0_we  = 1'b0;
   logic [SW-1:0] m0_sel = '1;
   logic          m0_stb = 1'b0;
   logic          m0_cyc = 1'b0;
   logic [DW-1:0] m0_dat_o;
   logic          m0_ack_o;
   logic          m0_err_o;

   logic [AW-1:0] m1_adr = '0;
   logic [DW-1:0] m1_dat = '0;
   logic          m1_we  = 1'b0;
   logic [SW-1:0] m1_sel = '1;
   logic          m1_stb = 1'b0;
   logic          m1_cyc = 1'b0;
   logic [DW-1:0] m1_dat_o;
   logic          m1_ack_o;
   logic          m1_err_o;

   logic [AW-1:0] s_adr_o;
   logic [DW-1:0] s_dat_o;
   logic          s_we_o;
   logic [SW-1:0] s_sel_o;
   logic          s_stb_o;
   logic          s_cyc_o;
   logic [DW-1:0] s_dat_i;
   logic          s_ack_i;

   logic          ram_ack = 1'b0;
   logic          stall   = 1'b0;
   logic          ack_inj = 1'b0;
   logic [DW-1:0] mem [0:255];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   wb_ram_arbiter #(
      .DATA_WIDTH  (DW),
      .ADDR_WIDTH  (AW),
      .SELECT_WIDTH(SW),
      .TIMEOUT     (TO)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .m0_adr_i(m0_adr),
      .m0_dat_i(m0_dat),
      .m0_dat_o(m0_dat_o),
      .m0_we_i (m0_we),
      .m0_sel_i(m0_sel),
      .m0_stb_i(m0_stb),
      .m0_cyc_i(m0_cyc),
      .m0_ack_o(m0_ack_o),
      .m0_err_o(m0_err_o),
      .m1_adr_i(m1_adr),
      .m1_dat_i(m1_dat),
      .m1_dat_o(m1_dat_o),
      .m1_we_i (m1_we),
      .m1_sel_i(m1_sel),
      .m1_stb_i(m1_stb),
      .m1_cyc_i(m1_cyc),
      .m1_ack_o(m1_ack_o),
      .m1_err_o(m1_err_o),
      .s_adr_o (s_adr_o),
      .s_dat_o (s_dat_o),
      .s_we_o  (s_we_o),
      .s_sel_o (s_sel_o),
      .s_stb_o (s_stb_o),
      .s_cyc_o (s_cyc_o),
      .s_dat_i (s_dat_i),
      .s_ack_i (s_ack_i)
   );

   // RAM model: registered ack one cycle after strobe, word addressed.
   assign s_ack_i = ram_ack | ack_inj;
   assign s_dat_i = mem[s_adr_o[9:2]];

   always @(posedge clk) begin
      ram_ack <= s_cyc_o & s_stb_o & ~ram_ack & ~stall;
      if (s_cyc_o && s_stb_o && s_we_o && !ram_ack && !stall)
         mem[s_adr_o[9:2]] <= s_dat_o;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic smp;
      @(negedge clk);
   endtask

   // Waits (bounded) until master m sees an ack; returns at that falling edge.
   task automatic wait_ack(input int m, input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         smp;
         if ((m == 0) ? m0_ack_o : m1_ack_o) begin
            seen = 1'b1;
            break;
         end
         tick;
      end
      chk(tag, 64'(seen), 64'd1);
   endtask

   // Both masters raise a read cycle together. With handover the loser
   // follows the winner with no gap; otherwise both drop after the winner's ack.
   task automatic run_tie(input bit exp_w, input bit handover);
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 16'h0100;
      m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0; m1_adr = 16'h0200;
      smp;
      chk("tie_latency_cyc", 64'(s_cyc_o), 64'd0);
      tick; smp;
      chk("tie_winner_adr", 64'(s_adr_o), exp_w ? 64'h0200 : 64'h0100);
      chk("tie_winner_cyc", 64'(s_cyc_o), 64'd1);
      wait_ack(int'(exp_w), "tie_winner_ack");
      chk("tie_loser_ack", 64'(exp_w ? m0_ack_o : m1_ack_o), 64'd0);
      tick;
      if (handover) begin
         if (exp_w) begin m1_cyc = 1'b0; m1_stb = 1'b0; end
         else       begin m0_cyc = 1'b0; m0_stb = 1'b0; end
         smp;
         chk("handover_drop_cyc", 64'(s_cyc_o), 64'd0);
         tick; smp;
         chk("handover_next_adr", 64'(s_adr_o), exp_w ? 64'h0100 : 64'h0200);
         chk("handover_next_cyc", 64'(s_cyc_o), 64'd1);
         wait_ack(int'(!exp_w), "handover_ack");
         tick;
      end
      m0_cyc = 1'b0; m0_stb = 1'b0;
      m1_cyc = 1'b0; m1_stb = 1'b0;
      tick;
   endtask

   initial begin
      int got;
      int m1a;
      int viol;
      int errs;
      bit seen;

      // Reset: outputs quiet even with a master requesting.
      m0_cyc = 1'b1; m0_stb = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      smp;
      chk("rst_s_cyc", 64'(s_cyc_o), 64'd0);
      chk("rst_s_stb", 64'(s_stb_o), 64'd0);
      chk("rst_m0_ack", 64'(m0_ack_o), 64'd0);
      chk("rst_m1_ack", 64'(m1_ack_o), 64'd0);
      chk("rst_m0_err", 64'(m0_err_o), 64'd0);
      tick;
      m0_cyc = 1'b0; m0_stb = 1'b0;
      rst = 1'b0;
      tick;

      // First tie with handover, then four abandoned ties alternating.
      run_tie(1'b0, 1'b1);
      run_tie(1'b0, 1'b0);
      run_tie(1'b1, 1'b0);
      run_tie(1'b0, 1'b0);
      run_tie(1'b1, 1'b0);

      // Single write by master 0 and read back.
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_adr = 16'h0010;
      m0_dat = 32'hDEADBEEF; m0_sel = 4'hF;
      smp;
      chk("wr_latency_cyc", 64'(s_cyc_o), 64'd0);
      tick; smp;
      chk("wr_s_cyc", 64'(s_cyc_o), 64'd1);
      chk("wr_s_we", 64'(s_we_o), 64'd1);
      chk("wr_s_dat", 64'(s_dat_o), 64'hDEADBEEF);
      chk("wr_s_sel", 64'(s_sel_o), 64'hF);
      chk("wr_m0_ack_early", 64'(m0_ack_o), 64'd0);
      tick; smp;
      chk("wr_m0_ack", 64'(m0_ack_o), 64'd1);
      chk("wr_m1_ack", 64'(m1_ack_o), 64'd0);
      tick;
      m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
      smp;
      chk("wr_m0_ack_single", 64'(m0_ack_o), 64'd0);
      tick;
      m0_cyc = 1'b1; m0_stb = 1'b1;
      tick;
      wait_ack(0, "rd_ack");
      chk("rd_data", 64'(m0_dat_o), 64'hDEADBEEF);
      chk("rd_m1_ack", 64'(m1_ack_o), 64'd0);
      tick;
      m0_cyc = 1'b0; m0_stb = 1'b0;
      tick;

      // Asynchronous reset in the middle of an acknowledged access.
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 16'h0010;
      tick;
      tick;
      #1;
      rst = 1'b1; ack_inj = 1'b1;
      #1;
      chk("midrst_s_cyc", 64'(s_cyc_o), 64'd0);
      chk("midrst_s_stb", 64'(s_stb_o), 64'd0);
      chk("midrst_m0_ack", 64'(m0_ack_o), 64'd0);
      chk("midrst_m1_ack", 64'(m1_ack_o), 64'd0);
      chk("midrst_m0_err", 64'(m0_err_o), 64'd0);
      tick;
      rst = 1'b0; ack_inj = 1'b0;
      m0_cyc = 1'b0; m0_stb = 1'b0;
      tick;
      run_tie(1'b0, 1'b0);

      // Four-strobe write burst by master 0 while master 1 waits.
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_adr = 16'h0000;
      m0_dat = 32'h11110000;
      tick;
      m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0; m1_adr = 16'h0004;
      got = 0; m1a = 0; viol = 0;
      for (int i = 0; i < 40 && got < 4; i++) begin
         smp;
         if (m1_ack_o) m1a++;
         if (s_cyc_o && s_adr_o != m0_adr) viol++;
         seen = m0_ack_o;
         if (seen) got++;
         tick;
         if (seen) begin
            if (got == 4) begin
               m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
            end else begin
               m0_adr = m0_adr + 16'h4;
               m0_dat = m0_dat + 32'h1;
            end
         end
      end
      chk("burst_m0_acks", 64'(got), 64'd4);
      chk("burst_m1_acks", 64'(m1a), 64'd0);
      chk("burst_grant_violations", 64'(viol), 64'd0);
      smp;
      chk("burst_drop_cyc", 64'(s_cyc_o), 64'd0);
      tick; smp;
      chk("burst_handover_adr", 64'(s_adr_o), 64'h0004);
      chk("burst_handover_cyc", 64'(s_cyc_o), 64'd1);
      wait_ack(1, "burst_m1_ack");
      chk("burst_m1_rdata", 64'(m1_dat_o), 64'h11110001);
      tick;
      m1_cyc = 1'b0; m1_stb = 1'b0;
      tick;

      // Master 1 drops CYC in the cycle its ack comes back.
      m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 16'h000C;
      tick;
      tick;
      m1_cyc = 1'b0; m1_stb = 1'b0;
      smp;
      chk("drop_m1_ack", 64'(m1_ack_o), 64'd0);
      chk("drop_m0_ack", 64'(m0_ack_o), 64'd0);
      tick;
      ack_inj = 1'b1;
      smp;
      chk("late_m1_ack", 64'(m1_ack_o), 64'd0);
      chk("late_m0_ack", 64'(m0_ack_o), 64'd0);
      tick;
      ack_inj = 1'b0;

      // Stalled slave.
      stall = 1'b1;
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 16'h0010;
      tick;
`ifdef WB_RAM_ARBITER_TIMEOUT_EN
      for (int c = 1; c <= 9; c++) begin
         smp;
         chk("wd_m0_err", 64'(m0_err_o), 64'(c == TO));
         chk("wd_s_stb", 64'(s_stb_o), 64'(c != TO));
         chk("wd_m1_err", 64'(m1_err_o), 64'd0);
         chk("wd_m0_ack", 64'(m0_ack_o), 64'd0);
         tick;
      end
`else
      errs = 0;
      for (int c = 0; c < 100; c++) begin
         smp;
         if (m0_err_o || m1_err_o) errs++;
         tick;
      end
      smp;
      chk("stall_no_err", 64'(errs), 64'd0);
      chk("stall_stb_held", 64'(s_stb_o), 64'd1);
      tick;
`endif
      m0_cyc = 1'b0; m0_stb = 1'b0;
      stall = 1'b0;
      tick;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench still running at %0t, limit 200000", $time);
      $fatal(1, "bench timeout");
   end

endmodule
